pc: RTL and testbench
=====================

// Module: pc
// PURPOSE
//   8-bit program counter of the processor core. Holds the address of the current instruction (endAtual).
//   Each clock it either holds, increments, loads a jump target (novoEnd), performs a call, or performs a return.
//   Calls and returns use a small internal return-address stack.
//   It sits between the control unit (commands) and instruction memory (address).
// PARAMETERS
//   WIDTH        8      address width in bits
//   RESET_ADDR   8'h00  value of endAtual after reset
//   STACK_DEPTH  4      return-address stack entries (power of two, >=2)
// PORTS
//   clk         in   1      single system clock; all state updates on its rising edge
//   reset       in   1      synchronous, active-high reset
//   novoEnd     in   WIDTH  new address: jump/call target
//   carrega     in   1      load: endAtual <= novoEnd
//   incrementa  in   1      endAtual <= endAtual + 1
//   chama       in   1      call: push endAtual+1, endAtual <= novoEnd
//   retorna     in   1      return: endAtual <= popped address
//   endAtual    out  WIDTH  current address (registered)
//   pilhaVazia  out  1      stack holds 0 entries
//   pilhaCheia  out  1      stack holds STACK_DEPTH entries
//   erroPilha   out  1      sticky flag: overflow or underflow occurred
// BEHAVIOUR
//   - Reset (sync, active-high, wins over everything):
//     endAtual=RESET_ADDR; stack count=0 (pilhaVazia=1, pilhaCheia=0); erroPilha=0. Stack contents are don't-care.
//   - Command priority, evaluated each rising edge: retorna > chama > carrega > incrementa > hold.
//     Only the highest-priority asserted command acts; the others are ignored that cycle.
//   - Latency: 1 cycle. endAtual shows the new value right after the edge that samples the command.
//     endAtual has no combinational path from any input.
//   - incrementa: endAtual+1 modulo 2^WIDTH (8'hFF -> 8'h00, no flag).
//   - carrega: endAtual <= novoEnd. Every WIDTH-bit value is accepted.
//   - chama, stack not full:
//     push (endAtual+1) mod 2^WIDTH; endAtual <= novoEnd; count+1.
//   - chama, stack full:
//     jump still taken (endAtual <= novoEnd); push dropped; count and contents unchanged; erroPilha <= 1.
//   - retorna, stack not empty: endAtual <= top entry; count-1 (LIFO).
//   - retorna, stack empty: endAtual holds; count stays 0; erroPilha <= 1.
//   - erroPilha is sticky and is cleared only by reset.
//   - Flags are registered and reflect the count after the edge.
//   - Reset asserted in the same cycle as any command: reset values apply; the command is discarded.
//   - Inputs X/Z are not handled; the control unit guarantees known levels.
// STRUCTURE
//   - Shared package pc_pkg: PC_WIDTH=8, PC_RESET_ADDR=8'h00, PC_STACK_DEPTH=4, typedef pc_addr_t (logic [PC_WIDTH-1:0]).
//   - One sub-module: pc_pilha, the LIFO return stack.
//     Inputs: clk, reset, push, pop, din. Outputs: dout (top), vazia, cheia.
//     Ignores push when full and pop when empty.
//   - Top level: command priority decode, next-address mux, endAtual register, erroPilha register.
// TESTING
//   1. reset=1 for 2 cycles -> endAtual=8'h00, pilhaVazia=1, pilhaCheia=0, erroPilha=0.
//   2. carrega=1 with novoEnd=8'h02, then 8'h03, then 8'h04, one cycle each
//      -> endAtual=02, 03, 04 on successive edges.
//   3. carrega novoEnd=8'hFE, then incrementa for 3 cycles -> endAtual=FF, 00, 01; erroPilha stays 0.
//   4. From endAtual=8'h10: chama novoEnd=8'h40, then chama novoEnd=8'h80, then retorna twice
//      -> endAtual=40, 80, 41, 11; pilhaVazia=1 at the end.
//   5. Five chama with targets 01..05 starting at 8'h20, then one retorna
//      -> pilhaCheia=1 after the 4th; the 5th jumps to 05 and sets erroPilha=1; retorna -> 04.
//   6. retorna on an empty stack -> endAtual unchanged, erroPilha=1.
//      Then carrega with reset=1 in the same cycle -> endAtual=00, erroPilha=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter slice.
//   PC_WIDTH        address width in bits
//   PC_RESET_ADDR   endAtual value after reset
//   PC_STACK_DEPTH  return-address stack entries (power of two, >=2)
//   pc_addr_t       address type
//   pc_cmd_t        decoded command, one per cycle
//   decodeCmd       priority decode: retorna > chama > carrega > incrementa > hold
package pc_pkg;

   localparam int PC_WIDTH       = 8;
   localparam int PC_STACK_DEPTH = 4;

   typedef logic [PC_WIDTH-1:0] pc_addr_t;

   localparam pc_addr_t PC_RESET_ADDR = 8'h00;

   typedef enum logic [2:0] {
      CMD_HOLD,
      CMD_INC,
      CMD_LOAD,
      CMD_CALL,
      CMD_RET
   } pc_cmd_t;

   // Only the highest-priority asserted command survives.
   function automatic pc_cmd_t decodeCmd(input logic ret, input logic call,
                                         input logic load, input logic inc);
      if (ret)       return CMD_RET;
      else if (call) return CMD_CALL;
      else if (load) return CMD_LOAD;
      else if (inc)  return CMD_INC;
      else           return CMD_HOLD;
   endfunction

endpackage

// File: rtl/pc_pilha.sv
// LIFO return-address stack for the program counter.
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset (empties the stack)
//   push   in   write din on top (ignored when full)
//   pop    in   discard top entry (ignored when empty)
//   din    in   WIDTH address to push
//   dout   out  WIDTH current top entry (don't-care when empty)
//   vazia  out  stack holds 0 entries
//   cheia  out  stack holds DEPTH entries
// push and pop are never requested together by the top level; push wins if they are.
module pc_pilha
   import pc_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH,
   parameter int DEPTH = PC_STACK_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             vazia,
   output logic             cheia
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      count;
   logic [PW-1:0]    topIdx;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (push && !cheia) begin
         count <= count + 1'b1;
      end else if (pop && !vazia) begin
         count <= count - 1'b1;
      end
   end

   // NOTE: storage has no reset; the count alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (!reset && push && !cheia) begin
         mem[count[PW-1:0]] <= din;
      end
   end

   // Wraps to the last slot when empty; the value is unused then.
   assign topIdx = count[PW-1:0] - PW'(1);
   assign dout   = mem[topIdx];

   // Flags decode the registered count, so they change only on a clock edge.
   assign vazia = (count == '0);
   assign cheia = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/pc.sv
// Program counter with call/return stack.
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset, wins over every command
//   novoEnd     in   WIDTH jump/call target
//   carrega     in   load novoEnd
//   incrementa  in   advance by one (wraps modulo 2^WIDTH)
//   chama       in   call: push endAtual+1, jump to novoEnd
//   retorna     in   return: jump to popped address
//   endAtual    out  WIDTH current instruction address (registered)
//   pilhaVazia  out  stack empty
//   pilhaCheia  out  stack full
//   erroPilha   out  sticky overflow/underflow flag, cleared only by reset
module pc
   import pc_pkg::*;
#(
   parameter int               WIDTH       = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_ADDR  = PC_RESET_ADDR,
   parameter int               STACK_DEPTH = PC_STACK_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] novoEnd,
   input  logic             carrega,
   input  logic             incrementa,
   input  logic             chama,
   input  logic             retorna,
   output logic [WIDTH-1:0] endAtual,
   output logic             pilhaVazia,
   output logic             pilhaCheia,
   output logic             erroPilha
);

   pc_cmd_t          cmd;
   logic [WIDTH-1:0] nextAddr;
   logic [WIDTH-1:0] retAddr;
   logic [WIDTH-1:0] topAddr;
   logic             pushReq;
   logic             popReq;
   logic             stackErr;

   assign cmd     = decodeCmd(retorna, chama, carrega, incrementa);
   assign retAddr = endAtual + WIDTH'(1);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      nextAddr = endAtual;
      pushReq  = 1'b0;
      popReq   = 1'b0;
      stackErr = 1'b0;
      case (cmd)
         CMD_RET: begin
            if (!pilhaVazia) begin
               nextAddr = topAddr;
               popReq   = 1'b1;
            end else begin
               stackErr = 1'b1;
            end
         end
         CMD_CALL: begin
            // The jump is taken even when the push has to be dropped.
            nextAddr = novoEnd;
            if (!pilhaCheia) pushReq  = 1'b1;
            else             stackErr = 1'b1;
         end
         CMD_LOAD: nextAddr = novoEnd;
         CMD_INC:  nextAddr = retAddr;
         default:  nextAddr = endAtual;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         endAtual  <= RESET_ADDR;
         erroPilha <= 1'b0;
      end else begin
         endAtual <= nextAddr;
         if (stackErr) erroPilha <= 1'b1;
      end
   end

   pc_pilha #(
      .WIDTH (WIDTH),
      .DEPTH (STACK_DEPTH)
   ) uPilha (
      .clk   (clk),
      .reset (reset),
      .push  (pushReq),
      .pop   (popReq),
      .din   (retAddr),
      .dout  (topAddr),
      .vazia (pilhaVazia),
      .cheia (pilhaCheia)
   );

endmodule

// File: tb/tb_pc.sv
// Testbench for pc: directed command sequence with literal expectations,
// plus a queue-based reference model compared on every falling edge.
module tb_pc;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] novoEnd;
   logic       carrega, incrementa, chama, retorna;
   logic [7:0] endAtual;
   logic       pilhaVazia, pilhaCheia, erroPilha;

   int checks = 0;
   int errors = 0;

   pc dut (
      .clk        (clk),
      .reset      (reset),
      .novoEnd    (novoEnd),
      .carrega    (carrega),
      .incrementa (incrementa),
      .chama      (chama),
      .retorna    (retorna),
      .endAtual   (endAtual),
      .pilhaVazia (pilhaVazia),
      .pilhaCheia (pilhaCheia),
      .erroPilha  (erroPilha)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: the PC as a number, the stack as a queue of return addresses.
   logic [7:0] mPc;
   logic [7:0] mStack [$];
   logic       mErr;
   bit         mValid = 0;

   always @(posedge clk) begin
      if (reset) begin
         mPc = 8'h00;
         mStack.delete();
         mErr = 1'b0;
         mValid = 1;
      end else if (mValid) begin
         if (retorna) begin
            if (mStack.size() > 0) mPc = mStack.pop_back();
            else                   mErr = 1'b1;
         end else if (chama) begin
            if (mStack.size() < 4) mStack.push_back(8'((mPc + 1) % 256));
            else                   mErr = 1'b1;
            mPc = novoEnd;
         end else if (carrega) begin
            mPc = novoEnd;
         end else if (incrementa) begin
            mPc = 8'((mPc + 1) % 256);
         end
      end
   end

   always @(negedge clk) begin
      if (mValid) begin
         check("model endAtual", int'(endAtual), int'(mPc));
         check("model pilhaVazia", int'(pilhaVazia), int'(mStack.size() == 0));
         check("model pilhaCheia", int'(pilhaCheia), int'(mStack.size() == 4));
         check("model erroPilha", int'(erroPilha), int'(mErr));
      end
   end

   // Drive one cycle of commands, then wait just past the sampling edge.
   task automatic step(input logic rst, input logic ret, input logic ch,
                       input logic ca, input logic inc, input logic [7:0] addr);
      reset      = rst;
      retorna    = ret;
      chama      = ch;
      carrega    = ca;
      incrementa = inc;
      novoEnd    = addr;
      @(posedge clk);
      #1;
   endtask

   task automatic expect4(input string name, input logic [7:0] a, input logic v,
                          input logic c, input logic e);
      check({name, " endAtual"}, int'(endAtual), int'(a));
      check({name, " pilhaVazia"}, int'(pilhaVazia), int'(v));
      check({name, " pilhaCheia"}, int'(pilhaCheia), int'(c));
      check({name, " erroPilha"}, int'(erroPilha), int'(e));
   endtask

   initial begin
      reset = 1'b1; retorna = 0; chama = 0; carrega = 0; incrementa = 0; novoEnd = 8'h00;

      // 1. reset for two cycles
      step(1, 0, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 0, 8'h00);
      expect4("reset", 8'h00, 1, 0, 0);

      // 2. successive loads
      step(0, 0, 0, 1, 0, 8'h02); check("load 02", int'(endAtual), 'h02);
      step(0, 0, 0, 1, 0, 8'h03); check("load 03", int'(endAtual), 'h03);
      step(0, 0, 0, 1, 0, 8'h04); check("load 04", int'(endAtual), 'h04);

      // 3. increment across the wrap
      step(0, 0, 0, 1, 0, 8'hFE); check("load FE", int'(endAtual), 'hFE);
      step(0, 0, 0, 0, 1, 8'h00); check("inc FF", int'(endAtual), 'hFF);
      step(0, 0, 0, 0, 1, 8'h00); check("inc wrap 00", int'(endAtual), 'h00);
      step(0, 0, 0, 0, 1, 8'h00); expect4("inc 01", 8'h01, 1, 0, 0);

      // 4. nested call/return
      step(0, 0, 0, 1, 0, 8'h10); check("load 10", int'(endAtual), 'h10);
      step(0, 0, 1, 0, 0, 8'h40); expect4("call 40", 8'h40, 0, 0, 0);
      step(0, 0, 1, 0, 0, 8'h80); check("call 80", int'(endAtual), 'h80);
      step(0, 1, 0, 0, 0, 8'h00); check("ret 41", int'(endAtual), 'h41);
      step(0, 1, 0, 0, 0, 8'h00); expect4("ret 11", 8'h11, 1, 0, 0);

      // 5. overflow: fifth call still jumps but sets the error
      step(0, 0, 0, 1, 0, 8'h20);
      step(0, 0, 1, 0, 0, 8'h01);
      step(0, 0, 1, 0, 0, 8'h02);
      step(0, 0, 1, 0, 0, 8'h03); expect4("call 3", 8'h03, 0, 0, 0);
      step(0, 0, 1, 0, 0, 8'h04); expect4("call 4 full", 8'h04, 0, 1, 0);
      step(0, 0, 1, 0, 0, 8'h05); expect4("call 5 overflow", 8'h05, 0, 1, 1);
      step(0, 1, 0, 0, 0, 8'h00); expect4("ret after ovf", 8'h04, 0, 0, 1);

      // priority: chama beats carrega/incrementa, retorna beats all
      step(1, 0, 0, 0, 0, 8'h00); expect4("reset 2", 8'h00, 1, 0, 0);
      step(0, 0, 1, 1, 1, 8'h50); expect4("prio call", 8'h50, 0, 0, 0);
      step(0, 1, 1, 1, 1, 8'h99); expect4("prio ret", 8'h01, 1, 0, 0);

      // 6. underflow, then reset overriding a load
      step(0, 0, 0, 1, 0, 8'h33);
      step(0, 1, 0, 0, 0, 8'h00); expect4("underflow", 8'h33, 1, 0, 1);
      step(0, 0, 0, 0, 0, 8'h00); check("err sticky", int'(erroPilha), 1);
      step(1, 0, 0, 1, 0, 8'h77); expect4("reset+load", 8'h00, 1, 0, 0);

      step(0, 0, 0, 0, 0, 8'h00);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
